// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: run/pause/lap stopwatch sequencer driving a synchronous
// BCD digit chain from two single-cycle button pulses.
// Optional build macro STOPWATCH_SAT_EN: saturate at all-9s with a sticky
// overflow flag instead of wrapping to zero.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_ss,
    input  logic                    btn_lr,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    lap_active,
    output logic                    tick,
    output logic                    wrap
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [DW-1:0]   lap_q, lap_d;
    logic            wrap_q, wrap_d;
    logic            running_q, running_d;
    logic            lap_active_q, lap_active_d;

    logic            counting;
    logic            presc_top;
    logic            all_nines;
    logic            tick_int;
    logic            clear;
    logic            carry;

    // Detect the all-9s digit pattern that precedes a wrap (or saturation).
    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
    end

    // Count enable: the prescaler terminal value while the watch is running.
    always_comb begin
        counting  = (state_q == S_RUN) || (state_q == S_LAP);
        presc_top = (presc_q == PRESC_MAX);
`ifdef STOPWATCH_SAT_EN
        tick_int  = counting && presc_top && !all_nines;
`else
        tick_int  = counting && presc_top;
`endif
    end

    // Button-driven state transitions; start/stop takes priority over lap/reset.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (btn_ss) begin
                    state_d = S_PAUSE;
                end else if (btn_lr) begin
                    state_d = S_LAP;
                    lap_d   = digits_q;
                end
            end
            S_LAP: begin
                if (btn_ss)      state_d = S_PAUSE;
                else if (btn_lr) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (btn_ss) begin
                    state_d = S_RUN;
                end else if (btn_lr) begin
                    state_d = S_IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d    = (state_d == S_RUN) || (state_d == S_LAP);
        lap_active_d = (state_d == S_LAP);
    end

    // Prescaler: free-runs while counting, retains its value while paused.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (counting) begin
`ifdef STOPWATCH_SAT_EN
            if (all_nines && presc_top) presc_d = presc_q;
            else if (presc_top)         presc_d = '0;
            else                        presc_d = presc_q + 1'b1;
`else
            if (presc_top) presc_d = '0;
            else           presc_d = presc_q + 1'b1;
`endif
        end
    end

    // Ripple the tick through the digits as an enable: a digit advances only
    // when every lower digit is at 9.
    always_comb begin
        digits_d = digits_q;
        carry    = tick_int;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    digits_d[4*i +: 4] = 4'd0;
                end else begin
                    digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        if (clear) digits_d = '0;
    end

    // Wrap pulse after rollover, or sticky overflow when saturating.
    always_comb begin
`ifdef STOPWATCH_SAT_EN
        wrap_d = wrap_q || (counting && presc_top && all_nines);
`else
        wrap_d = tick_int && all_nines;
`endif
        if (clear) wrap_d = 1'b0;
    end

    // Single register bank for FSM, prescaler, digits, lap hold and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            digits_q     <= '0;
            lap_q        <= '0;
            wrap_q       <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            digits_q     <= digits_d;
            lap_q        <= lap_d;
            wrap_q       <= wrap_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    // Display mux: frozen lap value only while in LAP.
    always_comb begin
        count      = (state_q == S_LAP) ? lap_q : digits_q;
        running    = running_q;
        lap_active = lap_active_q;
        tick       = tick_int;
        wrap       = wrap_q;
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: a TICK_DIV=4/2-digit instance and a
// TICK_DIV=1/3-digit instance share one clock.
module tb_bcd_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset, btn_ss, btn_lr;
    logic [7:0]  count;
    logic        running, lap_active, tick, wrap;

    logic        reset2, btn_ss2, btn_lr2;
    logic [11:0] count2;
    logic        running2, lap_active2, tick2, wrap2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.TICK_DIV(4), .NUM_DIGITS(2)) u_dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .count(count), .running(running), .lap_active(lap_active),
        .tick(tick), .wrap(wrap)
    );

    bcd_stopwatch_ctrl #(.TICK_DIV(1), .NUM_DIGITS(3)) u_dut3 (
        .clk(clk), .reset(reset2), .btn_ss(btn_ss2), .btn_lr(btn_lr2),
        .count(count2), .running(running2), .lap_active(lap_active2),
        .tick(tick2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    endtask

    task automatic pulse_lr();
        btn_lr = 1'b1; cyc(1); btn_lr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(1); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        reset2 = 1'b1; btn_ss2 = 1'b0; btn_lr2 = 1'b0;
        cyc(2);
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_lap", 32'(lap_active), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);

        // btn_lr in IDLE is ignored
        pulse_lr();
        chk("idle_lr_running", 32'(running), 32'd0);

        // Plan 1: start, first tick, BCD carry into tens
        pulse_ss();
        chk("start_running", 32'(running), 32'd1);
        chk("start_tick0", 32'(tick), 32'd0);
        cyc(3);
        chk("first_tick", 32'(tick), 32'd1);
        chk("count_before_tick", 32'(count), 32'h00);
        cyc(1);
        chk("count_01", 32'(count), 32'h01);
        chk("tick_low_after", 32'(tick), 32'd0);
        cyc(35);
        chk("count_09", 32'(count), 32'h09);
        cyc(1);
        chk("count_10_bcd", 32'(count), 32'h10);

        // Plan 2: lap hold at 0x37, live counter keeps going
        cyc(108);
        chk("count_37", 32'(count), 32'h37);
        pulse_lr();
        chk("lap_active", 32'(lap_active), 32'd1);
        chk("lap_running", 32'(running), 32'd1);
        chk("lap_hold_37", 32'(count), 32'h37);
        cyc(7);
        chk("lap_still_37", 32'(count), 32'h37);
        pulse_lr();
        chk("lap_exit", 32'(lap_active), 32'd0);
        chk("live_39", 32'(count), 32'h39);

        // Plan 3: pause retains presc, resume, PAUSE+lr clears
        do_reset();
        pulse_ss();
        cyc(21);
        chk("count_05", 32'(count), 32'h05);
        pulse_ss();
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_tick", 32'(tick), 32'd0);
        cyc(20);
        chk("pause_hold_05", 32'(count), 32'h05);
        pulse_ss();
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_tick0", 32'(tick), 32'd0);
        cyc(1);
        chk("resume_tick1", 32'(tick), 32'd1);
        cyc(1);
        chk("count_06", 32'(count), 32'h06);
        pulse_ss();
        pulse_lr();
        chk("clear_count", 32'(count), 32'h00);
        chk("clear_running", 32'(running), 32'd0);
        pulse_ss();
        cyc(3);
        chk("clear_presc_tick", 32'(tick), 32'd1);

        // Plan 4: simultaneous buttons in RUN, reset in LAP
        btn_ss = 1'b1; btn_lr = 1'b1; cyc(1); btn_ss = 1'b0; btn_lr = 1'b0;
        chk("both_running", 32'(running), 32'd0);
        chk("both_lap", 32'(lap_active), 32'd0);
        chk("both_count", 32'(count), 32'h01);
        do_reset();
        pulse_ss();
        cyc(168);
        pulse_lr();
        chk("lap_42", 32'(count), 32'h42);
        chk("lap_42_active", 32'(lap_active), 32'd1);
        pulse_ss();
        chk("lap_ss_pause", 32'(running), 32'd0);
        chk("lap_ss_live", 32'(count), 32'h42);
        pulse_ss();
        pulse_lr();
        chk("relap_42", 32'(lap_active), 32'd1);
        do_reset();
        chk("rst_lap_count", 32'(count), 32'h00);
        chk("rst_lap_running", 32'(running), 32'd0);
        chk("rst_lap_active", 32'(lap_active), 32'd0);

        // Plan 5: wrap at 0x99
        pulse_ss();
        cyc(396);
        chk("count_99", 32'(count), 32'h99);
        cyc(3);
        chk("wrap_pre", 32'(wrap), 32'd0);
`ifdef STOPWATCH_SAT_EN
        chk("sat_tick", 32'(tick), 32'd0);
        cyc(1);
        chk("sat_count", 32'(count), 32'h99);
        chk("sat_wrap", 32'(wrap), 32'd1);
        cyc(8);
        chk("sat_hold", 32'(count), 32'h99);
        chk("sat_sticky", 32'(wrap), 32'd1);
`else
        chk("wrap_tick", 32'(tick), 32'd1);
        cyc(1);
        chk("wrap_count", 32'(count), 32'h00);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        cyc(1);
        chk("wrap_drop", 32'(wrap), 32'd0);
        chk("wrap_count_hold", 32'(count), 32'h00);
`endif

        // Plan 6: TICK_DIV=1, 3 digits
        reset2 = 1'b0;
        btn_ss2 = 1'b1; cyc(1); btn_ss2 = 1'b0;
        chk("d3_tick", 32'(tick2), 32'd1);
        chk("d3_start", 32'(count2), 32'h000);
        cyc(1);
        chk("d3_001", 32'(count2), 32'h001);
        cyc(98);
        chk("d3_099", 32'(count2), 32'h099);
        cyc(1);
        chk("d3_100", 32'(count2), 32'h100);
        cyc(899);
        chk("d3_999", 32'(count2), 32'h999);
        chk("d3_wrap_pre", 32'(wrap2), 32'd0);
        cyc(1);
`ifdef STOPWATCH_SAT_EN
        chk("d3_sat_count", 32'(count2), 32'h999);
        chk("d3_sat_wrap", 32'(wrap2), 32'd1);
`else
        chk("d3_wrap_count", 32'(count2), 32'h000);
        chk("d3_wrap_pulse", 32'(wrap2), 32'd1);
        cyc(1);
        chk("d3_after_wrap", 32'(count2), 32'h001);
        chk("d3_wrap_drop", 32'(wrap2), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
